// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter onto a single-port unified memory with
// alternating priority, per-transaction timeout and a pipeline stall.
module mem_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_rdata,
    output logic        inst_ack,
    input  logic        data_req,
    input  logic        data_we,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_ack,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        stall
);

    typedef enum logic [1:0] {IDLE, INST, DATA} state_t;

    localparam logic [9:0] CNT_LAST = 10'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        last_data_q, last_data_d;   // 1: previous grant went to DATA
    logic [9:0]  cnt_q, cnt_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] inst_rdata_q, inst_rdata_d;
    logic [31:0] data_rdata_q, data_rdata_d;
    logic        inst_ack_q, inst_ack_d;
    logic        data_ack_q, data_ack_d;
    logic        bus_err_q, bus_err_d;

    logic inst_elig, data_elig;

    // A requester whose ack is high this cycle is still holding req; skip it.
    assign inst_elig = inst_req & ~inst_ack_q;
    assign data_elig = data_req & ~data_ack_q;
    assign stall     = inst_elig | data_elig;

    always_comb begin
        state_d      = state_q;
        last_data_d  = last_data_q;
        cnt_d        = cnt_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        inst_ack_d   = 1'b0;
        data_ack_d   = 1'b0;
        bus_err_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (data_elig && (!inst_elig || !last_data_q)) begin
                    state_d     = DATA;
                    last_data_d = 1'b1;
                    cnt_d       = '0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = data_we;
                    mem_addr_d  = data_addr;
                    mem_wdata_d = data_wdata;
                end else if (inst_elig) begin
                    state_d     = INST;
                    last_data_d = 1'b0;
                    cnt_d       = '0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = inst_addr;
                    mem_wdata_d = '0;
                end
            end
            INST, DATA: begin
                cnt_d = cnt_q + 10'd1;
                // Ready wins over a timeout landing in the same cycle.
                if (mem_ready || (cnt_q == CNT_LAST)) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    bus_err_d = ~mem_ready;
                    if (state_q == INST) begin
                        inst_ack_d   = 1'b1;
                        inst_rdata_d = mem_ready ? mem_rdata : 32'd0;
                    end else begin
                        data_ack_d = 1'b1;
                        if (!mem_ready) begin
                            data_rdata_d = 32'd0;
                        end else if (!mem_we_q) begin
                            data_rdata_d = mem_rdata;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_data_q  <= 1'b0;
            cnt_q        <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
            inst_ack_q   <= 1'b0;
            data_ack_q   <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_data_q  <= last_data_d;
            cnt_q        <= cnt_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
            inst_ack_q   <= inst_ack_d;
            data_ack_q   <= data_ack_d;
            bus_err_q    <= bus_err_d;
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign inst_rdata = inst_rdata_q;
    assign data_rdata = data_rdata_q;
    assign inst_ack   = inst_ack_q;
    assign data_ack   = data_ack_q;
    assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, write, arbitration order, timeout,
// idle mem_ready and mid-transaction reset, with hand-computed expectations.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req, data_req, data_we, mem_ready;
    logic [31:0] inst_addr, data_addr, data_wdata, mem_rdata;
    logic [31:0] inst_rdata, data_rdata, mem_addr, mem_wdata;
    logic        inst_ack, data_ack, bus_err, mem_req, mem_we, stall;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_ack(inst_ack),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_rdata(data_rdata), .data_ack(data_ack), .bus_err(bus_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .stall(stall)
    );

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        inst_req = 0; data_req = 0; data_we = 0; mem_ready = 0;
        inst_addr = 0; data_addr = 0; data_wdata = 0; mem_rdata = 0;
        nxt();
        nxt();
        @(negedge clk);
        n_chk++; if ({mem_req, mem_we, inst_ack, data_ack, bus_err, stall} !== 6'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 000000", {mem_req, mem_we, inst_ack, data_ack, bus_err, stall}); end
        n_chk++; if ({mem_addr, mem_wdata, inst_rdata, data_rdata} !== 128'd0) begin
            n_fail++; $display("FAIL reset_data: got %h want 0", {mem_addr, mem_wdata, inst_rdata, data_rdata}); end
        nxt();
        rst = 1'b0;
    endtask

    task automatic test_single_fetch();
        nxt();
        inst_req = 1; inst_addr = 32'h0000_0010;
        @(negedge clk);
        n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL fetch_stall_c0: got %b want 1", stall); end
        n_chk++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL fetch_req_c0: got %b want 0", mem_req); end
        nxt();
        mem_ready = 1; mem_rdata = 32'h2008_0005;
        @(negedge clk);
        n_chk++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL fetch_req_c1: got %b want 1", mem_req); end
        n_chk++; if (mem_addr !== 32'h10) begin n_fail++; $display("FAIL fetch_addr_c1: got %h want 00000010", mem_addr); end
        n_chk++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL fetch_we_c1: got %b want 0", mem_we); end
        n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL fetch_stall_c1: got %b want 1", stall); end
        n_chk++; if (inst_ack !== 1'b0) begin n_fail++; $display("FAIL fetch_early_ack: got %b want 0", inst_ack); end
        nxt();
        mem_ready = 0; mem_rdata = 0;
        @(negedge clk);
        n_chk++; if (inst_ack !== 1'b1) begin n_fail++; $display("FAIL fetch_ack_c2: got %b want 1", inst_ack); end
        n_chk++; if (inst_rdata !== 32'h2008_0005) begin n_fail++; $display("FAIL fetch_rdata_c2: got %h want 20080005", inst_rdata); end
        n_chk++; if ({mem_req, bus_err, stall, data_ack} !== 4'b0) begin
            n_fail++; $display("FAIL fetch_c2_ctrl: got %b want 0000", {mem_req, bus_err, stall, data_ack}); end
        inst_req = 0;
        nxt();
        @(negedge clk);
        n_chk++; if ({inst_ack, mem_req, stall} !== 3'b0) begin
            n_fail++; $display("FAIL fetch_c3_idle: got %b want 000", {inst_ack, mem_req, stall}); end
    endtask

    task automatic test_data_write();
        nxt();
        data_req = 1; data_we = 1; data_addr = 32'h50; data_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL wr_stall_c0: got %b want 1", stall); end
        for (int c = 1; c <= 4; c++) begin
            nxt();
            if (c == 4) begin mem_ready = 1; mem_rdata = 32'h1234_5678; end
            @(negedge clk);
            n_chk++; if ({mem_req, mem_we, mem_addr, mem_wdata, data_ack} !== {1'b1, 1'b1, 32'h50, 32'hDEAD_BEEF, 1'b0}) begin
                n_fail++; $display("FAIL wr_bus_c%0d: got req=%b we=%b addr=%h wd=%h ack=%b want 1 1 00000050 deadbeef 0",
                                   c, mem_req, mem_we, mem_addr, mem_wdata, data_ack); end
        end
        nxt();
        mem_ready = 0; mem_rdata = 0;
        @(negedge clk);
        n_chk++; if (data_ack !== 1'b1) begin n_fail++; $display("FAIL wr_ack: got %b want 1", data_ack); end
        n_chk++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL wr_ready_vs_timeout: bus_err got %b want 0", bus_err); end
        n_chk++; if (data_rdata !== 32'd0) begin n_fail++; $display("FAIL wr_rdata: got %h want 0", data_rdata); end
        n_chk++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL wr_req_drop: got %b want 0", mem_req); end
        data_req = 0; data_we = 0;
        nxt();
        @(negedge clk);
        n_chk++; if (data_ack !== 1'b0) begin n_fail++; $display("FAIL wr_ack_once: got %b want 0", data_ack); end
    endtask

    task automatic test_arbitration();
        logic [31:0] ea [4];
        logic [31:0] rd [4];
        ea = '{32'h200, 32'h100, 32'h200, 32'h100};
        rd = '{32'hA000_0001, 32'hB000_0001, 32'hA000_0002, 32'hB000_0002};
        nxt();
        rst = 1;
        nxt();
        rst = 0;
        inst_req = 1; inst_addr = 32'h100;
        data_req = 1; data_we = 0; data_addr = 32'h200;
        for (int i = 0; i < 4; i++) begin
            nxt();
            mem_ready = 1; mem_rdata = rd[i];
            @(negedge clk);
            n_chk++; if ({mem_req, mem_addr} !== {1'b1, ea[i]}) begin
                n_fail++; $display("FAIL arb_grant%0d: got req=%b addr=%h want 1 %h", i, mem_req, mem_addr, ea[i]); end
            nxt();
            @(negedge clk);
            if (i % 2 == 0) begin
                n_chk++; if ({data_ack, inst_ack, data_rdata} !== {2'b10, rd[i]}) begin
                    n_fail++; $display("FAIL arb_ack%0d: got dack=%b iack=%b drd=%h want 1 0 %h", i, data_ack, inst_ack, data_rdata, rd[i]); end
            end else begin
                n_chk++; if ({data_ack, inst_ack, inst_rdata} !== {2'b01, rd[i]}) begin
                    n_fail++; $display("FAIL arb_ack%0d: got dack=%b iack=%b ird=%h want 0 1 %h", i, data_ack, inst_ack, inst_rdata, rd[i]); end
            end
            if (i == 2) data_req = 0;
            if (i == 3) inst_req = 0;
        end
        nxt();
        mem_ready = 0; mem_rdata = 0;
        @(negedge clk);
        n_chk++; if ({mem_req, inst_ack, data_ack, stall} !== 4'b0) begin
            n_fail++; $display("FAIL arb_done: got %b want 0000", {mem_req, inst_ack, data_ack, stall}); end
    endtask

    task automatic test_timeout();
        nxt();
        data_req = 1; data_we = 0; data_addr = 32'h80;
        @(negedge clk);
        for (int c = 1; c <= 4; c++) begin
            nxt();
            @(negedge clk);
            n_chk++; if ({mem_req, data_ack, bus_err} !== 3'b100) begin
                n_fail++; $display("FAIL to_wait_c%0d: got req/ack/err=%b want 100", c, {mem_req, data_ack, bus_err}); end
        end
        nxt();
        @(negedge clk);
        n_chk++; if ({mem_req, data_ack, bus_err} !== 3'b011) begin
            n_fail++; $display("FAIL to_abort: got req/ack/err=%b want 011", {mem_req, data_ack, bus_err}); end
        n_chk++; if (data_rdata !== 32'd0) begin n_fail++; $display("FAIL to_rdata: got %h want 0", data_rdata); end
        data_req = 0;
        nxt();
        @(negedge clk);
        n_chk++; if ({mem_req, data_ack, bus_err} !== 3'b000) begin
            n_fail++; $display("FAIL to_idle: got req/ack/err=%b want 000", {mem_req, data_ack, bus_err}); end
    endtask

    task automatic test_idle_ready();
        for (int c = 0; c < 2; c++) begin
            nxt();
            mem_ready = 1; mem_rdata = 32'hFFFF_FFFF;
            @(negedge clk);
            n_chk++; if ({mem_req, inst_ack, data_ack, bus_err} !== 4'b0) begin
                n_fail++; $display("FAIL idle_rdy_c%0d: got %b want 0000", c, {mem_req, inst_ack, data_ack, bus_err}); end
        end
        nxt();
        mem_ready = 0; mem_rdata = 0;
        @(negedge clk);
        n_chk++; if (inst_rdata !== 32'hB000_0002) begin n_fail++; $display("FAIL idle_irdata: got %h want b0000002", inst_rdata); end
        n_chk++; if (data_rdata !== 32'd0) begin n_fail++; $display("FAIL idle_drdata: got %h want 0", data_rdata); end
    endtask

    task automatic test_reset_mid();
        nxt();
        data_req = 1; data_we = 0; data_addr = 32'h300;
        nxt();
        @(negedge clk);
        n_chk++; if ({mem_req, mem_addr} !== {1'b1, 32'h300}) begin
            n_fail++; $display("FAIL rm_grant: got req=%b addr=%h want 1 00000300", mem_req, mem_addr); end
        nxt();
        rst = 1; data_req = 0;
        nxt();
        rst = 0;
        @(negedge clk);
        n_chk++; if ({mem_req, mem_we, inst_ack, data_ack, bus_err, stall} !== 6'b0) begin
            n_fail++; $display("FAIL rm_ctrl: got %b want 000000", {mem_req, mem_we, inst_ack, data_ack, bus_err, stall}); end
        n_chk++; if ({mem_addr, mem_wdata, inst_rdata, data_rdata} !== 128'd0) begin
            n_fail++; $display("FAIL rm_data: got %h want 0", {mem_addr, mem_wdata, inst_rdata, data_rdata}); end
        nxt();
        inst_req = 1; inst_addr = 32'h40;
        @(negedge clk);
        n_chk++; if ({mem_req, data_ack} !== 2'b00) begin n_fail++; $display("FAIL rm_noack: got %b want 00", {mem_req, data_ack}); end
        nxt();
        mem_ready = 1; mem_rdata = 32'hCAFE_0001;
        @(negedge clk);
        n_chk++; if ({mem_req, mem_addr} !== {1'b1, 32'h40}) begin
            n_fail++; $display("FAIL rm_fetch_grant: got req=%b addr=%h want 1 00000040", mem_req, mem_addr); end
        nxt();
        mem_ready = 0; mem_rdata = 0;
        @(negedge clk);
        n_chk++; if ({inst_ack, data_ack, bus_err, inst_rdata} !== {3'b100, 32'hCAFE_0001}) begin
            n_fail++; $display("FAIL rm_fetch_ack: got iack=%b dack=%b err=%b ird=%h want 1 0 0 cafe0001",
                               inst_ack, data_ack, bus_err, inst_rdata); end
        inst_req = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_fetch();
        test_data_write();
        test_arbitration();
        test_timeout();
        test_idle_ready();
        test_reset_mid();
        nxt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates a single-port unified memory between the pipeline's instruction-fetch port and its data (MEM-stage) port. Each requester raises a request and holds it until acknowledged. The arbiter registers the winning request onto the memory bus, waits for `mem_ready` (or a timeout), returns read data with a one-cycle ack pulse, and drives a stall to the pipeline while any request is outstanding. It sits between the CPU core (`pcF`/`instrF`, `aluoutM`/`writedataM`/`readdataM`/`memwriteM`) and the external memory.

## Interface
- `TIMEOUT`, 255: max cycles to wait for `mem_ready` per transaction; range 1..1023.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `inst_req`  in  1  fetch request; held high until `inst_ack`.
- `inst_addr`  in  32  fetch address (`pcF`).
- `inst_rdata`  out  32  fetched word (`instrF`); valid while `inst_ack`=1.
- `inst_ack`  out  1  one-cycle completion pulse for fetch.
- `data_req`  in  1  data request; held high until `data_ack`.
- `data_we`  in  1  1 = write (`memwriteM`), 0 = read.
- `data_addr`  in  32  data address (`aluoutM`).
- `data_wdata`  in  32  write data (`writedataM`).
- `data_rdata`  out  32  read word (`readdataM`); valid while `data_ack`=1.
- `data_ack`  out  1  one-cycle completion pulse for data.
- `bus_err`  out  1  pulses with an ack when that transaction timed out.
- `mem_req`  out  1  memory transaction active.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  32  memory address.
- `mem_wdata`  out  32  memory write data.
- `mem_rdata`  in  32  memory read data; sampled when `mem_ready`=1.
- `mem_ready`  in  1  memory completes the current transaction this cycle.
- `stall`  out  1  combinational: `(inst_req & ~inst_ack) | (data_req & ~data_ack)`.

## Operation
- States: IDLE, INST, DATA.
- IDLE: eligible requesters are `inst_req & ~inst_ack` and `data_req & ~data_ack`. A requester is not re-granted in the cycle its ack is high.
  - Only one requester eligible: grant it.
  - Both eligible: grant the one not granted last. `last_grant` resets to INST, so data wins the first contention.
  - On grant: register address, `we` and wdata onto the `mem_*` bus. Fetch grants force `mem_we`=0 and `mem_wdata`=0. Set `mem_req`=1, clear the timeout counter, go to INST or DATA, and update `last_grant`.
- INST/DATA: `mem_*` outputs hold stable and the 10-bit counter increments each cycle.
  - `mem_ready`=1: capture `mem_rdata` into the granted port's rdata register (writes leave `data_rdata` unchanged). Next cycle, pulse that ack, drop `mem_req` and return to IDLE.
  - Counter reaches `TIMEOUT-1` with `mem_ready`=0: abort. Next cycle, pulse ack and `bus_err`, set that rdata to 0, drop `mem_req` and return to IDLE.
  - `mem_ready` takes precedence over timeout in the same cycle.
- Requests are not re-sampled mid-transaction. Deasserting a req before its ack is a protocol violation, and the transaction still completes.
- `mem_ready` in IDLE is ignored.
- `rst` (any state, including mid-transaction): state=IDLE, `last_grant`=INST, counter=0. The memory transaction is abandoned with no ack.

## Timing
- Reset values: `mem_req`, `mem_we`, `inst_ack`, `data_ack`, `bus_err` = 0. `mem_addr`, `mem_wdata`, `inst_rdata`, `data_rdata` = 0.
- `stall` follows its inputs combinationally and reads 0 when no request is pending.
- Req seen at cycle 0 in IDLE:
  - `mem_req` high in cycles 1..k, where k is the first cycle with `mem_ready`=1.
  - ack and rdata in cycle k+1.
  - Minimum latency is 2 cycles (`mem_ready` high at cycle 1).
- Back-to-back: IDLE occupies the ack cycle, so the next grant issues at k+2 on `mem_*`. A second access therefore starts 1 cycle after the previous ack.
- Timeout: `mem_req` is high for exactly `TIMEOUT` cycles; ack and `bus_err` are high in cycle `TIMEOUT+1`.

## Test plan
- Single fetch, `inst_addr`=0x0000_0010, `mem_ready` at cycle 1, `mem_rdata`=0x2008_0005:
  - `mem_req`=1 and `mem_addr`=0x10 in cycle 1.
  - `inst_ack`=1 and `inst_rdata`=0x2008_0005 in cycle 2.
  - `stall`=1 in cycles 0..1.
- Data write, `data_we`=1, addr 0x50, wdata 0xDEAD_BEEF, memory ready after 3 wait cycles:
  - `mem_we`=1 and the bus holds stable for 4 cycles.
  - `data_ack` asserts once.
  - `data_rdata` remains 0.
- `inst_req` and `data_req` both high from reset, each completed once and re-requested:
  - Grant order DATA, INST, DATA, INST.
  - No requester is granted twice in a row while the other waits.
- `TIMEOUT`=4, `mem_ready` tied low on a read:
  - `mem_req` high exactly 4 cycles.
  - Then `data_ack`=`bus_err`=1 with `data_rdata`=0.
  - Return to IDLE.
- `rst` asserted in cycle 2 of a DATA transaction:
  - Next cycle, all outputs are at reset values and no ack is issued.
  - A fresh `inst_req` afterwards completes normally.
- `mem_ready` pulsed while IDLE with no request:
  - No ack, `mem_req` stays 0.
  - The rdata registers are unchanged.
